// File: rtl/vexu_pkg.sv
// vexu_pkg: opcode/operand-form codes, SEW encodings, sequencer states and the
// per-lane ALU helper shared by the vexu_seq slice.
package vexu_pkg;

  localparam logic [5:0] F6_ADD  = 6'b000000;
  localparam logic [5:0] F6_SUB  = 6'b000010;
  localparam logic [5:0] F6_MINU = 6'b000100;
  localparam logic [5:0] F6_MIN  = 6'b000101;
  localparam logic [5:0] F6_MAXU = 6'b000110;
  localparam logic [5:0] F6_MAX  = 6'b000111;
  localparam logic [5:0] F6_AND  = 6'b001001;
  localparam logic [5:0] F6_OR   = 6'b001010;
  localparam logic [5:0] F6_XOR  = 6'b001011;

  localparam logic [2:0] F3_OPIVV = 3'b000;
  localparam logic [2:0] F3_OPIVX = 3'b100;

  localparam logic [1:0] SEW_8    = 2'd0;
  localparam logic [1:0] SEW_16   = 2'd1;
  localparam logic [1:0] SEW_32   = 2'd2;
  localparam logic [1:0] SEW_RSVD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic f6_supported(input logic [5:0] f6);
    case (f6)
      F6_ADD, F6_SUB, F6_MINU, F6_MIN, F6_MAXU, F6_MAX,
      F6_AND, F6_OR, F6_XOR: f6_supported = 1'b1;
      default:               f6_supported = 1'b0;
    endcase
  endfunction

  // Operands are shifted so the lane MSB sits at bit 31; one 32-bit datapath
  // then gives correct wrap, signed and unsigned compares for any SEW.
  function automatic logic [31:0] lane_op(input logic [5:0] f6, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] an, bn, r;
    an = a << sh;
    bn = b << sh;
    case (f6)
      F6_ADD:  r = an + bn;
      F6_SUB:  r = an - bn;
      F6_MINU: r = (an < bn) ? an : bn;
      F6_MIN:  r = ($signed(an) < $signed(bn)) ? an : bn;
      F6_MAXU: r = (an > bn) ? an : bn;
      F6_MAX:  r = ($signed(an) > $signed(bn)) ? an : bn;
      F6_AND:  r = an & bn;
      F6_OR:   r = an | bn;
      F6_XOR:  r = an ^ bn;
      default: r = '0;
    endcase
    lane_op = r >> sh;
  endfunction

endpackage

// File: rtl/vexu_if.sv
// vexu_if: instruction offer/accept channel into the vector ALU sequencer.
interface vexu_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic            o_ready;
  logic [5:0]      i_funct6;
  logic [2:0]      i_funct3;
  logic [XLEN-1:0] i_rs1;
  logic [4:0]      i_vs1a;
  logic [4:0]      i_vs2a;
  logic [4:0]      i_vda;
  logic [1:0]      i_vsew;
  logic [1:0]      i_lmul;
  logic [31:0]     i_vl;

  modport master (
    output i_valid, i_funct6, i_funct3, i_rs1, i_vs1a, i_vs2a, i_vda, i_vsew, i_lmul, i_vl,
    input  o_ready
  );

  modport slave (
    input  i_valid, i_funct6, i_funct3, i_rs1, i_vs1a, i_vs2a, i_vda, i_vsew, i_lmul, i_vl,
    output o_ready
  );
endinterface

// File: rtl/vexu_alu.sv
// vexu_alu: combinational VLEN-wide ALU, partitioned into 8/16/32-bit lanes by SEW.
module vexu_alu
  import vexu_pkg::*;
#(
  parameter int VLEN = 128,
  parameter int XLEN = 32
) (
  input  logic [5:0]      funct6,
  input  logic            is_vx,
  input  logic [1:0]      sew,
  input  logic [XLEN-1:0] rs1,
  input  logic [VLEN-1:0] vs1,
  input  logic [VLEN-1:0] vs2,
  output logic [VLEN-1:0] res
);
  logic [31:0]     rs1_w;
  logic [VLEN-1:0] r8, r16, r32;

  // lane_op keeps only the low SEW bits of the scalar, which is the splat truncation
  assign rs1_w = 32'(rs1);

  for (genvar k = 0; k < VLEN/8; k++) begin : g_e8
    assign r8[k*8 +: 8] = 8'(lane_op(funct6, {24'b0, vs2[k*8 +: 8]},
                                     is_vx ? rs1_w : {24'b0, vs1[k*8 +: 8]}, 5'd24));
  end

  for (genvar k = 0; k < VLEN/16; k++) begin : g_e16
    assign r16[k*16 +: 16] = 16'(lane_op(funct6, {16'b0, vs2[k*16 +: 16]},
                                         is_vx ? rs1_w : {16'b0, vs1[k*16 +: 16]}, 5'd16));
  end

  for (genvar k = 0; k < VLEN/32; k++) begin : g_e32
    assign r32[k*32 +: 32] = lane_op(funct6, vs2[k*32 +: 32],
                                     is_vx ? rs1_w : vs1[k*32 +: 32], 5'd0);
  end

  always_comb begin
    res = '0;
    case (sew)
      SEW_8:   res = r8;
      SEW_16:  res = r16;
      SEW_32:  res = r32;
      default: res = '0;
    endcase
  end
endmodule

// File: rtl/vexu_seq.sv
// vexu_seq: sequences one vector integer op over an LMUL register group, one register per cycle.
// Build option VEXU_MASK_EN adds i_vm/i_v0 mask-undisturbed byte enables.
module vexu_seq
  import vexu_pkg::*;
#(
  parameter int VLEN = 128,
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  vexu_if.slave             ins,
`ifdef VEXU_MASK_EN
  input  logic              i_vm,
  input  logic [VLEN-1:0]   i_v0,
`endif
  output logic [4:0]        o_rada,
  output logic [4:0]        o_radb,
  input  logic [VLEN-1:0]   i_rdataa,
  input  logic [VLEN-1:0]   i_rdatab,
  output logic [4:0]        o_wad,
  output logic [VLEN-1:0]   o_wdata,
  output logic [VLEN/8-1:0] o_wbe,
  output logic              o_we,
  output logic              o_busy,
  output logic              o_done
);
  // state | meaning
  // IDLE  | o_ready high, waiting for an instruction
  // RUN   | one group register read and written per cycle
  // DONE  | single-cycle o_done pulse, then back to IDLE
  localparam int NBYTE  = VLEN/8;
  localparam int EIDX_W = $clog2(VLEN);

  state_t          state;
  logic [2:0]      idx, rem, nxt, in_last;
  logic            ready_q;
  logic [5:0]      f6_q;
  logic            is_vx_q, ok_q, vm_q;
  logic [XLEN-1:0] rs1_q;
  logic [4:0]      vs1a_q, vs2a_q, vda_q;
  logic [1:0]      sew_q;
  logic [31:0]     vl_q, in_vlmax, in_vl;
  logic [VLEN-1:0] v0_q, v0_in, alu_res;
  logic            vm_in, accept, in_vx, in_ok;

`ifdef VEXU_MASK_EN
  assign vm_in = i_vm;
  assign v0_in = i_v0;
`else
  assign vm_in = 1'b1;
  assign v0_in = '0;
`endif

  assign ins.o_ready = ready_q;
  assign accept      = ins.i_valid && ready_q;
  assign in_vx       = (ins.i_funct3 == F3_OPIVX);
  assign in_ok       = f6_supported(ins.i_funct6) && (in_vx || ins.i_funct3 == F3_OPIVV)
                       && (ins.i_vsew != SEW_RSVD);
  assign in_vlmax    = (32'(NBYTE) >> ins.i_vsew) << ins.i_lmul;
  assign in_vl       = (ins.i_vl > in_vlmax) ? in_vlmax : ins.i_vl;
  assign in_last     = 3'((4'd1 << ins.i_lmul) - 4'd1);
  assign nxt         = idx + 3'd1;

  // Element e of register i lives at byte offset (e mod per-reg) << sew.
  function automatic logic [NBYTE-1:0] calc_be(input logic [2:0] i, input logic [1:0] sew,
                                               input logic [31:0] vl, input logic vm,
                                               input logic [VLEN-1:0] v0);
    logic [31:0] e;
    calc_be = '0;
    for (int b = 0; b < NBYTE; b++) begin
      e = ((32'(NBYTE) >> sew) * 32'(i)) + (32'(b) >> sew);
      calc_be[b] = (e < vl) && (vm || ((e < 32'(VLEN)) && v0[e[EIDX_W-1:0]]));
    end
  endfunction

  vexu_alu #(.VLEN(VLEN), .XLEN(XLEN)) u_alu (
    .funct6 (f6_q),
    .is_vx  (is_vx_q),
    .sew    (sew_q),
    .rs1    (rs1_q),
    .vs1    (i_rdataa),
    .vs2    (i_rdatab),
    .res    (alu_res)
  );

  assign o_wdata = o_we ? alu_res : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      rem     <= '0;
      ready_q <= 1'b1;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_we    <= 1'b0;
      o_wbe   <= '0;
      o_wad   <= '0;
      o_rada  <= '0;
      o_radb  <= '0;
      f6_q    <= '0;
      is_vx_q <= 1'b0;
      ok_q    <= 1'b0;
      rs1_q   <= '0;
      vs1a_q  <= '0;
      vs2a_q  <= '0;
      vda_q   <= '0;
      sew_q   <= '0;
      vl_q    <= '0;
      vm_q    <= 1'b1;
      v0_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            f6_q    <= ins.i_funct6;
            is_vx_q <= in_vx;
            ok_q    <= in_ok;
            rs1_q   <= ins.i_rs1;
            vs1a_q  <= ins.i_vs1a;
            vs2a_q  <= ins.i_vs2a;
            vda_q   <= ins.i_vda;
            sew_q   <= ins.i_vsew;
            vl_q    <= in_vl;
            vm_q    <= vm_in;
            v0_q    <= v0_in;
            ready_q <= 1'b0;
            o_busy  <= 1'b1;
            if (ins.i_vl == 32'd0) begin
              state  <= ST_DONE;
              o_done <= 1'b1;
            end else begin
              state  <= ST_RUN;
              idx    <= '0;
              rem    <= in_last;
              o_rada <= ins.i_vs1a;
              o_radb <= ins.i_vs2a;
              o_wad  <= ins.i_vda;
              o_we   <= in_ok;
              o_wbe  <= in_ok ? calc_be(3'd0, ins.i_vsew, in_vl, vm_in, v0_in) : '0;
            end
          end
        end
        ST_RUN: begin
          if (rem == '0) begin
            state  <= ST_DONE;
            o_done <= 1'b1;
            o_we   <= 1'b0;
            o_wbe  <= '0;
            o_rada <= '0;
            o_radb <= '0;
            o_wad  <= '0;
          end else begin
            idx    <= nxt;
            rem    <= rem - 3'd1;
            o_rada <= vs1a_q + 5'(nxt);
            o_radb <= vs2a_q + 5'(nxt);
            o_wad  <= vda_q + 5'(nxt);
            o_wbe  <= ok_q ? calc_be(nxt, sew_q, vl_q, vm_q, v0_q) : '0;
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vexu_seq.sv
// tb_vexu_seq: table-driven bench for vexu_seq with a write scoreboard and regfile model.
module tb_vexu_seq;
  logic         clk = 1'b0;
  logic         rst;
  logic [4:0]   o_rada, o_radb, o_wad;
  logic [127:0] i_rdataa, i_rdatab, o_wdata;
  logic [15:0]  o_wbe;
  logic         o_we, o_busy, o_done;
`ifdef VEXU_MASK_EN
  logic         i_vm;
  logic [127:0] i_v0;
`endif

  vexu_if #(.XLEN(32)) ifc ();

  vexu_seq #(.VLEN(128), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .ins(ifc),
`ifdef VEXU_MASK_EN
    .i_vm(i_vm), .i_v0(i_v0),
`endif
    .o_rada(o_rada), .o_radb(o_radb), .i_rdataa(i_rdataa), .i_rdatab(i_rdatab),
    .o_wad(o_wad), .o_wdata(o_wdata), .o_wbe(o_wbe), .o_we(o_we),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  logic [127:0] rf [32];
  assign i_rdataa = rf[o_rada];
  assign i_rdatab = rf[o_radb];

  typedef struct {
    logic [5:0] f6; logic [2:0] f3; logic [1:0] sew; logic [1:0] lmul;
    logic [31:0] vl; logic [31:0] rs1; logic [4:0] vs1a; logic [4:0] vs2a; logic [4:0] vda;
    int nwe; int lat;
  } vec_t;

  typedef struct packed { logic [4:0] wad; logic [127:0] d; logic [15:0] be; } wr_t;

  vec_t vecs [16];
  wr_t  sbq [$];
  int   total = 0, bad = 0, wr_cnt = 0, log_n = 0;
  bit   mon_en = 1'b0;
  logic [4:0]   log_wad [16];
  logic [127:0] log_wdata [16];
  logic [15:0]  log_wbe [16];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic bit supported(input vec_t v);
    return (v.f6 inside {6'b000000, 6'b000010, 6'b000100, 6'b000101, 6'b000110,
                         6'b000111, 6'b001001, 6'b001010, 6'b001011})
           && (v.f3 == 3'b000 || v.f3 == 3'b100) && (v.sew != 2'd3);
  endfunction

  function automatic logic [127:0] exp_data(input vec_t v, input logic [127:0] va,
                                            input logic [127:0] vb);
    int w; logic [63:0] m, a, b, r; longint sa, sb; logic [127:0] out;
    w = 8 << v.sew;
    m = (64'd1 << w) - 64'd1;
    out = '0;
    for (int e = 0; e < 128 / w; e++) begin
      a = 64'(vb >> (e * w)) & m;
      b = (v.f3 == 3'b100) ? (64'(v.rs1) & m) : (64'(va >> (e * w)) & m);
      sa = longint'(a); if (a[w-1]) sa = sa - (longint'(1) << w);
      sb = longint'(b); if (b[w-1]) sb = sb - (longint'(1) << w);
      case (v.f6)
        6'b000000: r = (a + b) & m;
        6'b000010: r = (a - b) & m;
        6'b000100: r = (a < b) ? a : b;
        6'b000101: r = (sa < sb) ? a : b;
        6'b000110: r = (a > b) ? a : b;
        6'b000111: r = (sa > sb) ? a : b;
        6'b001001: r = a & b;
        6'b001010: r = a | b;
        6'b001011: r = a ^ b;
        default:   r = '0;
      endcase
      out = out | (128'(r) << (e * w));
    end
    return out;
  endfunction

  function automatic logic [15:0] exp_be(input int i, input vec_t v, input logic vm,
                                         input logic [127:0] v0);
    int epr, vlmax, e; longint vle; logic [15:0] be;
    epr = 16 >> v.sew;
    vlmax = epr << v.lmul;
    vle = (longint'(v.vl) > vlmax) ? vlmax : longint'(v.vl);
    for (int b = 0; b < 16; b++) begin
      e = i * epr + b / (1 << v.sew);
      be[b] = (e < vle) && (vm || v0[e]);
    end
    return be;
  endfunction

  always @(negedge clk) begin
    if (mon_en && o_we) begin
      wr_t x;
      wr_cnt++;
      if (log_n < 16) begin
        log_wad[log_n] = o_wad; log_wdata[log_n] = o_wdata; log_wbe[log_n] = o_wbe;
        log_n++;
      end
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write: got write to %0d want none", o_wad);
      end else begin
        x = sbq.pop_front();
        chk("wad", o_wad, x.wad);
        chk("wbe", o_wbe, x.be);
        chk("wdata", o_wdata, x.d);
      end
    end
  end

  task automatic drive(input vec_t v, input logic vm, input logic [127:0] v0);
    ifc.i_funct6 = v.f6; ifc.i_funct3 = v.f3; ifc.i_rs1 = v.rs1;
    ifc.i_vs1a = v.vs1a; ifc.i_vs2a = v.vs2a; ifc.i_vda = v.vda;
    ifc.i_vsew = v.sew; ifc.i_lmul = v.lmul; ifc.i_vl = v.vl;
`ifdef VEXU_MASK_EN
    i_vm = vm; i_v0 = v0;
`endif
    ifc.i_valid = 1'b1;
  endtask

  task automatic run_op(input vec_t v, input logic vm, input logic [127:0] v0, input bit hold);
    int cyc, nwe;
    @(posedge clk); #1;
    chk("ready_idle", ifc.o_ready, 1'b1);
    log_n = 0;
    drive(v, vm, v0);
    if (supported(v) && v.vl != 0)
      for (int i = 0; i < (1 << v.lmul); i++)
        sbq.push_back('{wad: 5'(v.vda + 5'(i)),
                        d: exp_data(v, rf[5'(v.vs1a + 5'(i))], rf[5'(v.vs2a + 5'(i))]),
                        be: exp_be(i, v, vm, v0)});
    @(posedge clk); #1;
    if (hold) begin ifc.i_vda = 5'd7; ifc.i_vl = 32'd1; end
    else ifc.i_valid = 1'b0;
    cyc = 1; nwe = 0;
    while (!o_done && cyc < 40) begin
      if (o_we) nwe++;
      if (hold) chk("ready_busy", ifc.o_ready, 1'b0);
      @(posedge clk); #1;
      cyc++;
    end
    ifc.i_valid = 1'b0;
    chk("done_lat", cyc, v.lat);
    chk("we_count", nwe, v.nwe);
    chk("busy_done", o_busy, 1'b1);
    @(posedge clk); #1;
    chk("ready_after", ifc.o_ready, 1'b1);
    chk("done_clr", o_done, 1'b0);
    chk("busy_clr", o_busy, 1'b0);
    chk("sb_empty", sbq.size(), 0);
  endtask

  initial begin
    vec_t v;
    int base;
    vecs[0]  = '{6'b000000, 3'b000, 2'd2, 2'd0, 32'd4,   32'h0,         5'd1,  5'd2,  5'd20, 1, 2};
    vecs[1]  = '{6'b000010, 3'b100, 2'd0, 2'd0, 32'd16,  32'h105,       5'd0,  5'd3,  5'd21, 1, 2};
    vecs[2]  = '{6'b000000, 3'b000, 2'd1, 2'd2, 32'd20,  32'h0,         5'd10, 5'd14, 5'd30, 4, 5};
    vecs[3]  = '{6'b000111, 3'b000, 2'd0, 2'd0, 32'd16,  32'h0,         5'd5,  5'd4,  5'd22, 1, 2};
    vecs[4]  = '{6'b000110, 3'b000, 2'd0, 2'd0, 32'd16,  32'h0,         5'd5,  5'd4,  5'd23, 1, 2};
    vecs[5]  = '{6'b000101, 3'b000, 2'd1, 2'd0, 32'd8,   32'h0,         5'd6,  5'd7,  5'd24, 1, 2};
    vecs[6]  = '{6'b000100, 3'b100, 2'd2, 2'd0, 32'd4,   32'h8000_0001, 5'd0,  5'd7,  5'd25, 1, 2};
    vecs[7]  = '{6'b001001, 3'b000, 2'd0, 2'd1, 32'd20,  32'h0,         5'd6,  5'd8,  5'd26, 2, 3};
    vecs[8]  = '{6'b001010, 3'b100, 2'd1, 2'd0, 32'd3,   32'h1234_abcd, 5'd0,  5'd9,  5'd27, 1, 2};
    vecs[9]  = '{6'b001011, 3'b000, 2'd2, 2'd3, 32'd100, 32'h0,         5'd16, 5'd24, 5'd8,  8, 9};
    vecs[10] = '{6'b000001, 3'b000, 2'd2, 2'd1, 32'd8,   32'h0,         5'd6,  5'd7,  5'd9,  0, 3};
    vecs[11] = '{6'b000000, 3'b001, 2'd2, 2'd0, 32'd4,   32'h0,         5'd6,  5'd7,  5'd9,  0, 2};
    vecs[12] = '{6'b000000, 3'b000, 2'd3, 2'd0, 32'd4,   32'h0,         5'd6,  5'd7,  5'd9,  0, 2};
    vecs[13] = '{6'b000000, 3'b000, 2'd2, 2'd2, 32'd0,   32'h0,         5'd6,  5'd7,  5'd9,  0, 1};
    vecs[14] = '{6'b000010, 3'b000, 2'd2, 2'd1, 32'd5,   32'h0,         5'd6,  5'd8,  5'd11, 2, 3};
    vecs[15] = '{6'b000101, 3'b100, 2'd0, 2'd0, 32'd16,  32'hffff_fff0, 5'd0,  5'd18, 5'd12, 1, 2};

    for (int r = 0; r < 32; r++) rf[r] = {$urandom, $urandom, $urandom, $urandom};
    rf[1] = {32'd4, 32'd3, 32'd2, 32'd1};
    rf[2] = {32'd40, 32'd30, 32'd20, 32'd10};
    rf[3] = {16{8'h03}};
    rf[4] = {16{8'h80}};
    rf[5] = {16{8'h01}};

    rst = 1'b1;
    ifc.i_valid = 1'b0; ifc.i_funct6 = '0; ifc.i_funct3 = '0; ifc.i_rs1 = '0;
    ifc.i_vs1a = '0; ifc.i_vs2a = '0; ifc.i_vda = '0; ifc.i_vsew = '0; ifc.i_lmul = '0;
    ifc.i_vl = '0;
`ifdef VEXU_MASK_EN
    i_vm = 1'b1; i_v0 = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ifc.o_ready, 1'b1);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_we", o_we, 1'b0);
    chk("rst_wbe", o_wbe, 16'h0);
    chk("rst_wad", o_wad, 5'd0);
    chk("rst_wdata", o_wdata, 128'h0);
    chk("rst_rada", o_rada, 5'd0);
    chk("rst_radb", o_radb, 5'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    for (int vi = 0; vi < 16; vi++) begin
      run_op(vecs[vi], 1'b1, 128'h0, vi == 2);
      if (vi == 0) begin
        chk("vadd_lit", log_wdata[0], 128'h0000002c_00000021_00000016_0000000b);
        chk("vadd_be", log_wbe[0], 16'hffff);
      end
      if (vi == 1) chk("vsub_vx_lit", log_wdata[0], {16{8'hfe}});
      if (vi == 2) begin
        chk("grp_wad0", log_wad[0], 5'd30); chk("grp_wad2", log_wad[2], 5'd0);
        chk("grp_wad3", log_wad[3], 5'd1);  chk("grp_be1", log_wbe[1], 16'hffff);
        chk("grp_be2", log_wbe[2], 16'h00ff); chk("grp_be3", log_wbe[3], 16'h0000);
      end
      if (vi == 3) chk("vmax_lit", log_wdata[0], {16{8'h01}});
      if (vi == 4) chk("vmaxu_lit", log_wdata[0], {16{8'h80}});
    end

`ifdef VEXU_MASK_EN
    run_op(vecs[0], 1'b0, 128'h5, 1'b0);
    chk("mask_wbe", log_wbe[0], 16'h0f0f);
`endif

    // abort an LMUL8 op with reset during its second write cycle
    v = '{6'b000000, 3'b000, 2'd2, 2'd3, 32'd32, 32'h0, 5'd8, 5'd16, 5'd24, 8, 9};
    @(posedge clk); #1;
    drive(v, 1'b1, 128'h0);
    for (int i = 0; i < 2; i++)
      sbq.push_back('{wad: 5'(v.vda + 5'(i)), d: exp_data(v, rf[5'(v.vs1a + 5'(i))],
                      rf[5'(v.vs2a + 5'(i))]), be: exp_be(i, v, 1'b1, 128'h0)});
    @(posedge clk); #1;
    ifc.i_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_we_t2", o_we, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_ready", ifc.o_ready, 1'b1);
    chk("abort_busy", o_busy, 1'b0);
    chk("abort_we", o_we, 1'b0);
    chk("abort_wad", o_wad, 5'd0);
    chk("abort_wbe", o_wbe, 16'h0);
    base = wr_cnt;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_no_writes", wr_cnt - base, 0);
    chk("abort_sb_empty", sbq.size(), 0);

    run_op(vecs[6], 1'b1, 128'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
